// File: rtl/mem_access_responder.sv
// Word-store responder for multicycle CPU fetch/load/store requests with fixed wait states.
// Optional MEM_ERR_CHECK_EN flags misaligned or out-of-range requests via resp_err.
module mem_access_responder #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              resp_err_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              accept_c;
    logic [IDX_W-1:0]  req_idx_c;
    logic              req_err_c;
    logic              cur_we_c;
    logic [IDX_W-1:0]  cur_idx_c;
    logic [DATA_W-1:0] cur_wdata_c;
    logic              cur_err_c;
    logic              enter_resp_c;
    logic              mem_we_c;

    assign accept_c  = (state_q == S_IDLE) && req_valid;
    assign req_idx_c = req_addr[IDX_W+1:2];

`ifdef MEM_ERR_CHECK_EN
    assign req_err_c = (req_addr[1:0] != 2'b00) || ((req_addr >> (IDX_W + 2)) != '0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[1:0], req_addr[ADDR_W-1:IDX_W+2]};
    assign req_err_c        = 1'b0;
`endif

    // With zero wait states the request is served on its own accept edge, before latching.
    assign cur_we_c    = accept_c ? req_we    : we_q;
    assign cur_idx_c   = accept_c ? req_idx_c : idx_q;
    assign cur_wdata_c = accept_c ? req_wdata : wdata_q;
    assign cur_err_c   = accept_c ? req_err_c : err_q;

    assign enter_resp_c = (state_d == S_RESP);
    assign mem_we_c     = enter_resp_c && cur_we_c && !cur_err_c && !reset;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control, request latch and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= (state_d == S_IDLE);
            resp_valid_q <= enter_resp_c;
            if (accept_c) begin
                we_q    <= req_we;
                idx_q   <= req_idx_c;
                wdata_q <= req_wdata;
                err_q   <= req_err_c;
            end
            if (enter_resp_c) begin
                resp_rdata_q <= (cur_we_c || cur_err_c) ? '0 : mem_q[cur_idx_c];
                resp_err_q   <= cur_err_c;
            end
        end
    end

    // Word store; not cleared by reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[cur_idx_c] <= cur_wdata_c;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_responder.sv
// Directed bench for mem_access_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_mem_access_responder;

    logic        clk;
    logic        reset;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        d0_req_valid;
    logic        d0_req_ready;
    logic        d0_req_we;
    logic [31:0] d0_req_addr;
    logic [31:0] d0_req_wdata;
    logic        d0_resp_valid;
    logic [31:0] d0_resp_rdata;
    logic        d0_resp_err;

    logic        cur_sel;
    logic        m_ready;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        m_err;

    int vectors;
    int miscompares;
    int cyc;
    int acc [4];
    int lat;

    mem_access_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    mem_access_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(d0_req_valid), .req_ready(d0_req_ready), .req_we(d0_req_we),
        .req_addr(d0_req_addr), .req_wdata(d0_req_wdata),
        .resp_valid(d0_resp_valid), .resp_rdata(d0_resp_rdata), .resp_err(d0_resp_err)
    );

    assign m_ready  = cur_sel ? d0_req_ready  : req_ready;
    assign m_rvalid = cur_sel ? d0_resp_valid : resp_valid;
    assign m_rdata  = cur_sel ? d0_resp_rdata : resp_rdata;
    assign m_err    = cur_sel ? d0_resp_err   : resp_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full request on the selected instance; exp_lat counts edges after the accept edge.
    task automatic do_req(input bit sel, input string tag, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
        int l;
        cur_sel = sel;
        #1;
        chk({tag, "_ready"}, 32'(m_ready), 32'd1);
        if (sel) begin
            d0_req_valid = 1'b1; d0_req_we = we; d0_req_addr = addr; d0_req_wdata = wdata;
        end else begin
            req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        end
        @(posedge clk); #1;
        d0_req_valid = 1'b0;
        req_valid    = 1'b0;
        l = 0;
        while (!m_rvalid && l < 20) begin
            @(posedge clk); #1;
            l++;
        end
        chk({tag, "_seen"},  32'(m_rvalid), 32'd1);
        chk({tag, "_lat"},   32'(l), 32'(exp_lat));
        chk({tag, "_rdata"}, m_rdata, exp_rdata);
        chk({tag, "_err"},   32'(m_err), 32'(exp_err));
        @(posedge clk); #1;
        chk({tag, "_drop"},  32'(m_rvalid), 32'd0);
        chk({tag, "_hold"},  m_rdata, exp_rdata);
        chk({tag, "_idle"},  32'(m_ready), 32'd1);
    endtask

    initial begin
        vectors = 0; miscompares = 0; cur_sel = 1'b0;
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        d0_req_valid = 1'b0; d0_req_we = 1'b0; d0_req_addr = '0; d0_req_wdata = '0;

        // 1. reset values
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_ready",   32'(req_ready),  32'd1);
        chk("rst_rvalid",  32'(resp_valid), 32'd0);
        chk("rst_rdata",   resp_rdata,      32'd0);
        chk("rst_err",     32'(resp_err),   32'd0);
        chk("rst0_ready",  32'(d0_req_ready),  32'd1);
        chk("rst0_rvalid", 32'(d0_resp_valid), 32'd0);

        // 2. store then load
        do_req(0, "t2_st", 1'b1, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0);
        do_req(0, "t2_ld", 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0);

        // 3. preload words 0..3 then back-to-back loads with req_valid held high
        for (int i = 0; i < 4; i++) begin
            do_req(0, "t3_pre", 1'b1, 32'(4 * i), 32'h1000_0000 + 32'(i), 2, 32'h0, 1'b0);
        end
        req_valid = 1'b1;
        req_we    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_addr = 32'(4 * i);
            @(posedge clk); #1;
            acc[i] = cyc;
            lat = 0;
            while (!resp_valid && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            chk("t3_seen",  32'(resp_valid), 32'd1);
            chk("t3_rdata", resp_rdata, 32'h1000_0000 + 32'(i));
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            chk("t3_spacing", 32'(acc[i] - acc[i-1]), 32'd4);
        end

        // 4. out-of-range store aliases word 0 unless error checking is enabled
`ifdef MEM_ERR_CHECK_EN
        do_req(0, "t4_st", 1'b1, 32'h400, 32'h1234, 2, 32'h0, 1'b1);
        do_req(0, "t4_ld", 1'b0, 32'h0, 32'h0, 2, 32'h1000_0000, 1'b0);
`else
        do_req(0, "t4_st", 1'b1, 32'h400, 32'h1234, 2, 32'h0, 1'b0);
        do_req(0, "t4_ld", 1'b0, 32'h0, 32'h0, 2, 32'h0000_1234, 1'b0);
`endif

        // 5. reset during WAIT drops an uncommitted store
        do_req(0, "t5_pre", 1'b1, 32'h20, 32'h5555, 2, 32'h0, 1'b0);
        cur_sel = 1'b0;
        #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("t5_busy", 32'(req_ready), 32'd0);
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("t5_ready",  32'(req_ready),  32'd1);
        chk("t5_rvalid", 32'(resp_valid), 32'd0);
        chk("t5_rdata",  resp_rdata,      32'd0);
        do_req(0, "t5_ld", 1'b0, 32'h20, 32'h0, 2, 32'h5555, 1'b0);

        // 6. zero wait states, unaligned load
        do_req(1, "t6_st", 1'b1, 32'h10, 32'hCAFE0004, 0, 32'h0, 1'b0);
`ifdef MEM_ERR_CHECK_EN
        do_req(1, "t6_ld", 1'b0, 32'h13, 32'h0, 0, 32'h0, 1'b1);
`else
        do_req(1, "t6_ld", 1'b0, 32'h13, 32'h0, 0, 32'hCAFE0004, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
